// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, one-cycle response.
// Optional store logging is enabled with `define DM_RESPONDER_DISPLAY_EN.
module dm_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] Limit = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept, commit, addr_err, mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   old_word, merged;

  assign idx      = addr_q[AW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q >= Limit);
  assign old_word = mem_q[idx];
  assign mem_we   = commit && we_q && !addr_err;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    accept     = 1'b0;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          err_d   = addr_err;
          rdata_d = addr_err ? 32'h0 : (we_q ? merged : old_word);
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        be_q    <= req_be;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
    end else if (mem_we) begin
      mem_q[idx] <= merged;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

`ifdef DM_RESPONDER_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset && mem_we && (be_q != 4'h0)) begin
      $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, merged);
    end
  end
`else
  // PC is captured only for the optional store log.
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder against a transaction-level model of the memory.
module tb_dm_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned W     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request accepted at edge acc commits at acc+W+1; busy until acc+W+2.
  int unsigned e = 0;
  int unsigned acc = 0;
  bit          pend = 1'b0;
  bit          took = 1'b0;
  bit          m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wd;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] x_rdata = 32'h0;
  bit          x_err = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    bit          can;
    bit          er;
    int unsigned wi;
    logic [31:0] w;
    took = 1'b0;
    if (reset) begin
      pend    = 1'b0;
      x_rdata = 32'h0;
      x_err   = 1'b0;
      foreach (m_mem[i]) m_mem[i] = 32'h0;
    end else begin
      can = !pend;
      e++;
      if (pend && e == acc + W + 1) begin
        er = ((m_addr % 4) != 0) || (m_addr >= DEPTH * 4);
        if (er) begin
          x_err   = 1'b1;
          x_rdata = 32'h0;
        end else begin
          wi = m_addr / 4;
          w  = m_mem[wi];
          if (m_we) begin
            for (int b = 0; b < 4; b++) begin
              if (m_be[b]) w = (w & ~(32'hFF << (8 * b))) | (m_wd & (32'hFF << (8 * b)));
            end
          end
          m_mem[wi] = w;
          x_err     = 1'b0;
          x_rdata   = w;
        end
      end
      if (pend && e == acc + W + 2) pend = 1'b0;
      if (can && req_valid) begin
        pend   = 1'b1;
        acc    = e;
        took   = 1'b1;
        m_we   = req_we;
        m_be   = req_be;
        m_addr = req_addr;
        m_wd   = req_wdata;
      end
    end
  end

  int unsigned pulses = 0;

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(!pend));
    chk("resp_valid", 32'(resp_valid), 32'(pend && (e == acc + W + 1)));
    chk("resp_rdata", resp_rdata, x_rdata);
    chk("resp_err", 32'(resp_err), 32'(x_err));
    if (resp_valid === 1'b1) pulses++;
  end

  task automatic issue(input bit we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n;
    n         = 0;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wd;
    req_pc    = $urandom;
    req_valid = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 50);
    chk("accepted", 32'(took), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] rd, output bit er);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid !== 1'b1 && n < 40);
    chk("resp_seen", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    er = resp_err;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rd;
    bit          er;
    int unsigned a0, a1, p0, r, r2;
    logic [31:0] addr;

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Load of reset memory and response timing.
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    a0 = acc;
    wait_resp(rd, er);
    chk("t1_rdata", rd, 32'h0);
    chk("t1_err", 32'(er), 32'd0);
    chk("t1_latency", e - a0, 32'd3);
    @(negedge clk);
    chk("t1_ready_back", 32'(req_ready), 32'd1);

    issue(1'b1, 4'hF, 32'h10, 32'h12345678);
    wait_resp(rd, er);
    chk("t2_store", rd, 32'h12345678);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    wait_resp(rd, er);
    chk("t2_load", rd, 32'h12345678);

    issue(1'b1, 4'b0010, 32'h10, 32'hAABBCCDD);
    wait_resp(rd, er);
    chk("t3_store", rd, 32'h1234CC78);
    issue(1'b0, 4'hF, 32'h10, 32'h0);
    wait_resp(rd, er);
    chk("t3_load", rd, 32'h1234CC78);

    issue(1'b1, 4'hF, 32'h11, 32'hFFFFFFFF);
    wait_resp(rd, er);
    chk("t4_mis_err", 32'(er), 32'd1);
    chk("t4_mis_rdata", rd, 32'h0);
    issue(1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF);
    wait_resp(rd, er);
    chk("t4_oor_err", 32'(er), 32'd1);
    chk("t4_oor_rdata", rd, 32'h0);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    wait_resp(rd, er);
    chk("t4_load", rd, 32'h1234CC78);

    // Second request held valid during WAIT is taken only after RESP.
    @(posedge clk);
    #1 p0 = pulses;
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    a0 = acc;
    issue(1'b0, 4'h0, 32'h4, 32'h0);
    a1 = acc;
    chk("t5_second_accept", a1 - a0, W + 3);
    wait_resp(rd, er);
    chk("t5_rdata", rd, 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("t5_pulses", pulses - p0, 32'd2);

    // Reset during WAIT discards the store.
    issue(1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_valid", 32'(resp_valid), 32'd0);
    issue(1'b0, 4'h0, 32'h20, 32'h0);
    wait_resp(rd, er);
    chk("t6_load", rd, 32'h0);

    for (int it = 0; it < 400; it++) begin
      r    = $urandom_range(0, 19);
      addr = 32'($urandom_range(0, 15) * 4);
      if (r == 0) addr = addr + 32'($urandom_range(1, 3));
      if (r == 1) addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      if (r == 2) addr = $urandom & 32'hFFFF_FFFC;
      if (r == 3) addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      if (r == 4) addr = 32'hFFC;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom);
      r2 = $urandom_range(0, 19);
      if (r2 == 0) begin
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
      end else if (r2 < 10) begin
        wait_resp(rd, er);
      end
    end

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
